// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the FSM state enum, the instruction word layout and the opcode/HALT constants.
package program_loader_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] HALT_OP = 5'b00000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        WAIT_LO = 3'd2,
        WRITE   = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Instruction word as it arrives on the wire: high byte first.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } instr_word_t;

    // Opcode field lives in the top OPCODE_W bits of the word.
    function automatic logic is_halt(input instr_word_t w);
        return w.hi[BYTE_W-1 -: OPCODE_W] == HALT_OP;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-pair assembler for the program loader.
// Holds the high byte and presents {hi, byte} when the low byte arrives.
// With LOADER_CHECKSUM_EN defined it also keeps a running XOR of every accepted byte.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          restart: zero the high-byte (and checksum) registers
//   byte_in        received data byte
//   byte_valid     byte_in is an accepted data byte this cycle
//   byte_lo        this accepted byte is the low half of a word
//   word_c         combinational {hi, byte_in}
//   word_valid_c   combinational: word_c is complete this cycle
//   csum           running XOR of accepted bytes (LOADER_CHECKSUM_EN only)
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_lo,
    output instr_word_t       word_c,
    output logic              word_valid_c
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0] csum
`endif
);

    logic [BYTE_W-1:0] hi_q;

    // High-byte holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (clear) begin
            hi_q <= '0;
        end else if (byte_valid && !byte_lo) begin
            hi_q <= byte_in;
        end
    end

    assign word_c       = '{hi: hi_q, lo: byte_in};
    assign word_valid_c = byte_valid && byte_lo;

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every data byte of the current load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (byte_valid) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

endmodule

// File: rtl/program_loader.sv
// Program memory writer: turns a UART byte stream into instruction words.
// Byte pairs (high first) are written to ascending addresses from 0 until a
// HALT word is written or the last address is filled.
// Optional macro LOADER_CHECKSUM_EN: one trailing checksum byte is compared
// against the XOR of all data bytes before done rises.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        1-cycle pulse: begin a load at address 0 (ignored while busy)
//   rx_data      received byte, qualified by rx_valid
//   wr_en        memory write enable, one cycle per word
//   wr_addr      write address
//   wr_data      write data
//   busy         load in progress
//   done         load finished, held until next start
//   overflow     memory filled without HALT
//   word_count   words written in current/last load
//   chk_err      checksum mismatch (0 without LOADER_CHECKSUM_EN)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned AB = 11,
    parameter int unsigned DB = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [AB-1:0]     wr_addr,
    output logic [DB-1:0]     wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [AB:0]       word_count,
    output logic              chk_err
);

    state_e      state;
    instr_word_t word_c;
    logic        word_valid_c;
    logic        halt_c;
    logic        last_c;
    logic        term_c;
    logic        restart_c;
    logic        byte_valid_c;
    logic        byte_lo_c;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    // Termination is judged on the word currently being written.
    assign halt_c    = is_halt(instr_word_t'(wr_data[2*BYTE_W-1:0]));
    assign last_c    = (wr_addr == {AB{1'b1}});
    assign term_c    = halt_c || last_c;
    assign restart_c = start && (state == IDLE || state == DONE);

    // A data byte is accepted while assembling, or during a non-final WRITE
    // where it becomes the next high byte.
    assign byte_valid_c = rx_valid && ((state == WAIT_HI) || (state == WAIT_LO) ||
                                       ((state == WRITE) && !term_c));
    assign byte_lo_c    = (state == WAIT_LO);

    loader_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (restart_c),
        .byte_in      (rx_data),
        .byte_valid   (byte_valid_c),
        .byte_lo      (byte_lo_c),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
`ifdef LOADER_CHECKSUM_EN
        ,
        .csum         (csum)
`endif
    );

    // Load sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            chk_err    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT_HI;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        chk_err    <= 1'b0;
                        wr_addr    <= '0;
                        word_count <= '0;
                    end
                end
                WAIT_HI: begin
                    if (rx_valid) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (word_valid_c) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_data <= DB'(word_c);
                    end
                end
                WRITE: begin
                    word_count <= word_count + (AB+1)'(1);
                    if (term_c) begin
                        overflow <= !halt_c;
`ifdef LOADER_CHECKSUM_EN
                        state    <= CHECK;
`else
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`endif
                    end else begin
                        wr_addr <= wr_addr + AB'(1);
                        state   <= rx_valid ? WAIT_LO : WAIT_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_valid) begin
                        chk_err <= (rx_data != csum);
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (default AB=11, DB=16).
// The expected write list is derived directly from the byte stream.
module tb_program_loader;

    localparam int AB    = 11;
    localparam int DB    = 16;
    localparam int DEPTH = 1 << AB;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AB:0]   word_count;
    logic          chk_err;

    program_loader #(.AB(AB), .DB(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed memory writes.
    int cap_addr[$];
    int cap_data[$];
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            cap_addr.push_back(int'(wr_addr));
            cap_data.push_back(int'(wr_data));
        end
    end

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [7:0] stim[$];
    int         exp_data[$];
    int         n_used;
    bit         e_ovf;
    logic [7:0] e_csum;

    // Pair bytes high-first; stop after a HALT word or once memory is full.
    function automatic void model();
        int w;
        exp_data.delete();
        e_ovf  = 1'b0;
        n_used = 0;
        e_csum = 8'h00;
        for (int i = 0; i + 1 < stim.size(); i += 2) begin
            w = {stim[i], stim[i+1]};
            exp_data.push_back(w);
            n_used = i + 2;
            if ((w >> 11) == 0) break;
            if (exp_data.size() == DEPTH) begin
                e_ovf = 1'b1;
                break;
            end
        end
        for (int i = 0; i < n_used; i++) e_csum = e_csum ^ stim[i];
    endfunction

    function automatic void push_word(input bit halt);
        if (halt) stim.push_back(8'($urandom_range(0, 7)));
        else      stim.push_back(8'($urandom_range(8, 255)));
        stim.push_back(8'($urandom_range(0, 255)));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            rx_data  = 8'hFF;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_chk_err"},    32'(chk_err),    32'd0);
    endtask

    // Full load: start, data bytes (optional mid-load start pulse), checksum,
    // trailing bytes after done, then compare everything against the model.
    task automatic run_load(input string tag, input int gap, input int start_at,
                            input bit combo, input bit bad_csum);
        int k;
        model();
        cap_addr.delete();
        cap_data.delete();
        pulse_start(combo);
        chk({tag, "_busy_start"},  32'(busy),       32'd1);
        chk({tag, "_done_clr"},    32'(done),       32'd0);
        chk({tag, "_count_clr"},   32'(word_count), 32'd0);
        for (int i = 0; i < n_used; i++) begin
            if (i == start_at) pulse_start(1'b0);
            send(stim[i]);
            idle(gap);
        end
`ifdef LOADER_CHECKSUM_EN
        idle(1);
        send(bad_csum ? (e_csum ^ 8'h5A) : e_csum);
`endif
        k = 0;
        while (done !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"},     32'(done),       32'd1);
        chk({tag, "_busy_end"}, 32'(busy),       32'd0);
        chk({tag, "_overflow"}, 32'(overflow),   32'(e_ovf));
        chk({tag, "_count"},    32'(word_count), 32'(exp_data.size()));
        chk({tag, "_addr"},     32'(wr_addr),    32'(exp_data.size() - 1));
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_chk_err"},  32'(chk_err),    32'(bad_csum));
`else
        chk({tag, "_chk_err"},  32'(chk_err),    32'd0);
`endif
        idle(2);
        for (int i = n_used; i < stim.size(); i++) send(stim[i]);
        idle(3);
        chk({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < cap_addr.size(); i++) begin
            chk({tag, "_waddr"}, 32'(cap_addr[i]), 32'(i));
            chk({tag, "_wdata"}, 32'(cap_data[i]), 32'(exp_data[i]));
        end
        chk({tag, "_done_held"}, 32'(done),       32'd1);
        chk({tag, "_cnt_held"},  32'(word_count), 32'(exp_data.size()));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // Bytes while idle must not write.
        send(8'h08); send(8'h01); send(8'h00); send(8'h00);
        idle(3);
        chk("idle_nwrites", 32'(cap_addr.size()), 32'd0);
        chk("idle_busy",    32'(busy),            32'd0);

        // Basic load ending on HALT.
        stim = '{8'h08, 8'h01, 8'h00, 8'h00};
        run_load("basic", 1, -1, 1'b0, 1'b0);

        // Restart from DONE with a byte on the start cycle (dropped).
        stim.delete();
        repeat (3) push_word(1'b0);
        push_word(1'b1);
        run_load("restart", 1, -1, 1'b1, 1'b0);

        // Reset in the middle of a load.
        cap_addr.delete();
        cap_data.delete();
        pulse_start(1'b0);
        send(8'h18);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        stim = '{8'h20, 8'h04, 8'h00, 8'h00};
        run_load("after_rst", 1, -1, 1'b0, 1'b0);

        // Start pulses while busy are ignored.
        stim.delete();
        repeat (6) push_word(1'b0);
        push_word(1'b1);
        run_load("start_busy", 2, 5, 1'b0, 1'b0);

        // Back-to-back bytes: the byte on the WRITE cycle is the next high byte;
        // bytes after HALT are ignored.
        stim.delete();
        repeat (5) push_word(1'b0);
        push_word(1'b1);
        repeat (2) push_word(1'b0);
        run_load("b2b", 0, -1, 1'b0, 1'b0);

        // Randomized loads with random pacing.
        for (int r = 0; r < 4; r++) begin
            stim.delete();
            repeat ($urandom_range(1, 12)) push_word(1'b0);
            push_word(1'b1);
            run_load("rand", $urandom_range(0, 3), -1, 1'b0, 1'b0);
        end

        // Fill memory without HALT; the extra word must not be written.
        stim.delete();
        repeat (DEPTH + 1) push_word(1'b0);
        run_load("full", 0, -1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte.
        stim = '{8'h08, 8'h01, 8'h00, 8'h00};
        run_load("bad_csum", 1, -1, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
